// File: rtl/mc_col_if.sv
// Host request/response bundle for the mc column controller.
// Master is the host; slave is the controller.
interface mc_col_if #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mc_col_ctrl.sv
// Sequences bitline drive/release and a single wordline pulse for one-word mc array accesses.
// Latency WL_CYC+3 cycles from accept to rsp_valid; one request in flight, req_ready only in IDLE.
module mc_col_ctrl #(
    parameter int ROWS   = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8,
    parameter int WL_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_col_if.slave          host,
    output logic [ROWS-1:0]  wl,
    output logic             bl_oe,
    output logic [WIDTH-1:0] bl_o,
    output logic [WIDTH-1:0] blb_o,
    input  logic [WIDTH-1:0] bl_i,
    input  logic [WIDTH-1:0] blb_i
);
    typedef enum logic [2:0] {IDLE, SETUP, WL_ON, HOLD, DONE} state_t;

    localparam int                CNT_W    = (WL_CYC > 1) ? $clog2(WL_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WL_CYC - 1);
    localparam logic [ADDR_W:0]   ROWS_LIM = (ADDR_W + 1)'(ROWS);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wl_cnt;
    logic              we_q, rng_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  samp_dat;
    logic              samp_err;

    logic              accept, wl_last;
    logic              we_n, rng_n, drive_n;
    logic [ADDR_W-1:0] addr_n;
    logic [WIDTH-1:0]  wdata_n;

    assign accept  = host.req_valid && host.req_ready;
    assign wl_last = (wl_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = WL_ON;
            WL_ON:   if (wl_last) state_nxt = HOLD;
            HOLD:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands for the cycle being entered: the live request on the accepting edge, else the latch.
    always_comb begin
        we_n    = accept ? host.req_we    : we_q;
        addr_n  = accept ? host.req_addr  : addr_q;
        wdata_n = accept ? host.req_wdata : wdata_q;
        rng_n   = ({1'b0, addr_n} < ROWS_LIM);
        drive_n = we_n && rng_n &&
                  (state_nxt == SETUP || state_nxt == WL_ON || state_nxt == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wl_cnt         <= '0;
            we_q           <= 1'b0;
            rng_q          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            samp_dat       <= '0;
            samp_err       <= 1'b0;
            wl             <= '0;
            bl_oe          <= 1'b0;
            bl_o           <= '0;
            blb_o          <= '0;
            host.req_ready <= 1'b1;
            host.rsp_valid <= 1'b0;
            host.rsp_rdata <= '0;
            host.rsp_err   <= 1'b0;
        end else begin
            state  <= state_nxt;
            wl_cnt <= (state == WL_ON) ? wl_cnt + CNT_W'(1) : '0;
            if (accept) begin
                we_q    <= host.req_we;
                addr_q  <= host.req_addr;
                wdata_q <= host.req_wdata;
                rng_q   <= rng_n;
            end
            host.req_ready <= (state_nxt == IDLE);
            wl    <= (state_nxt == WL_ON && rng_n) ? (ROWS'(1) << addr_n) : '0;
            bl_oe <= drive_n;
            bl_o  <= drive_n ? wdata_n  : '0;
            blb_o <= drive_n ? ~wdata_n : '0;
            // Sense on the edge closing the last wordline cycle, while the cells still drive the pairs.
            if (state == WL_ON && wl_last) begin
                samp_dat <= bl_i;
                samp_err <= |(bl_i ~^ blb_i);
            end
            host.rsp_valid <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                host.rsp_rdata <= (!we_q && rng_q) ? samp_dat : '0;
                host.rsp_err   <= !rng_q || (!we_q && samp_err);
            end
        end
    end
endmodule

// File: tb/tb_mc_col_ctrl.sv
module tb_mc_col_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rd;
        logic        err;
        int          cyc;
        logic [15:0] wl;
        int          wlcnt;
        int          oecnt;
        int          nrdy;
        logic [7:0]  wd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int tests = 0;
    int errs = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: 16 rows, 2-cycle wordline, with a behavioural cell array attached
    mc_col_if #(.ADDR_W(4), .WIDTH(8)) a_if ();
    logic [15:0] a_wl;
    logic        a_bl_oe;
    logic [7:0]  a_bl_o, a_blb_o, a_bl_i, a_blb_i;

    mc_col_ctrl #(.ROWS(16), .ADDR_W(4), .WIDTH(8), .WL_CYC(2)) u_a (
        .clk(clk), .rst_n(rst_n), .host(a_if.slave), .wl(a_wl), .bl_oe(a_bl_oe),
        .bl_o(a_bl_o), .blb_o(a_blb_o), .bl_i(a_bl_i), .blb_i(a_blb_i)
    );

    // DUT B: 12 rows, 4-cycle wordline, fixed sensed pattern
    mc_col_if #(.ADDR_W(4), .WIDTH(8)) b_if ();
    logic [11:0] b_wl;
    logic        b_bl_oe;
    logic [7:0]  b_bl_o, b_blb_o;
    logic [7:0]  b_bl_i = 8'h96;
    logic [7:0]  b_blb_i = 8'h69;

    mc_col_ctrl #(.ROWS(12), .ADDR_W(4), .WIDTH(8), .WL_CYC(4)) u_b (
        .clk(clk), .rst_n(rst_n), .host(b_if.slave), .wl(b_wl), .bl_oe(b_bl_oe),
        .bl_o(b_bl_o), .blb_o(b_blb_o), .bl_i(b_bl_i), .blb_i(b_blb_i)
    );

    // Cell array: strong drive wins, otherwise the selected row drives, otherwise pairs float high
    logic [7:0] mem [16];
    logic [7:0] exp_mem [16];
    logic       load = 1'b1;
    logic       flt = 1'b0;

    function automatic logic [7:0] init_val(int r);
        return (r == 4) ? 8'h3C : 8'(r * 17);
    endfunction

    always_comb begin
        a_bl_i  = 8'hFF;
        a_blb_i = 8'hFF;
        if (!flt) begin
            if (a_bl_oe) begin
                a_bl_i  = a_bl_o;
                a_blb_i = a_blb_o;
            end else begin
                for (int r = 0; r < 16; r++) begin
                    if (a_wl[r]) begin
                        a_bl_i  = mem[r];
                        a_blb_i = ~mem[r];
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < 16; r++) begin
            if (load) mem[r] <= init_val(r);
            else if (a_bl_oe && a_wl[r]) mem[r] <= a_bl_o;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_rsp(string t, exp_t e, logic [7:0] rd, logic er, int wlc, int oec,
                           int nrdy, logic bad);
        chk({t, "_rdata"}, rd, e.rd);
        chk({t, "_err"}, er, e.err);
        chk({t, "_rsp_cycle"}, cyc, e.cyc);
        chk({t, "_wl_cycles"}, wlc, e.wlcnt);
        chk({t, "_oe_cycles"}, oec, e.oecnt);
        chk({t, "_ready_low_cycles"}, nrdy, e.nrdy);
        chk({t, "_wl_bl_value_errors"}, bad, 0);
    endtask

    function automatic exp_t mk(logic we, int addr, logic [7:0] wd, int rows, int wlc,
                                logic [7:0] rdv, logic fl);
        exp_t e;
        logic in_rng;
        in_rng  = addr < rows;
        e.rd    = (!we && in_rng) ? (fl ? 8'hFF : rdv) : 8'h00;
        e.err   = !in_rng || (!we && fl);
        e.cyc   = cyc + wlc + 3;
        e.wl    = in_rng ? (16'h1 << addr) : 16'h0;
        e.wlcnt = in_rng ? wlc : 0;
        e.oecnt = (we && in_rng) ? wlc + 2 : 0;
        e.nrdy  = wlc + 3;
        e.wd    = wd;
        return e;
    endfunction

    // Monitors: accumulate per-access observations, compare when rsp_valid appears
    int a_wlc, a_oec, a_nrdy, b_wlc, b_oec, b_nrdy;
    logic a_bad, b_bad, a_rdy_chk, b_rdy_chk;
    exp_t ea, eb;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_wlc = 0; a_oec = 0; a_nrdy = 0; a_bad = 1'b0; a_rdy_chk = 1'b0;
        end else begin
            if (a_rdy_chk) begin
                chk("a_ready_after_done", a_if.req_ready, 1);
                a_rdy_chk = 1'b0;
            end
            if (!a_if.req_ready) a_nrdy++;
            if (a_wl != 0) begin
                a_wlc++;
                if (qa.size() == 0 || a_wl != qa[0].wl) a_bad = 1'b1;
            end
            if (a_bl_oe) begin
                a_oec++;
                if (qa.size() == 0 || a_bl_o != qa[0].wd || a_blb_o != ~qa[0].wd) a_bad = 1'b1;
            end
            if (a_if.rsp_valid) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_rsp", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    chk_rsp("a", ea, a_if.rsp_rdata, a_if.rsp_err, a_wlc, a_oec, a_nrdy, a_bad);
                    a_rdy_chk = 1'b1;
                end
                a_wlc = 0; a_oec = 0; a_nrdy = 0; a_bad = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_wlc = 0; b_oec = 0; b_nrdy = 0; b_bad = 1'b0; b_rdy_chk = 1'b0;
        end else begin
            if (b_rdy_chk) begin
                chk("b_ready_after_done", b_if.req_ready, 1);
                b_rdy_chk = 1'b0;
            end
            if (!b_if.req_ready) b_nrdy++;
            if (b_wl != 0) begin
                b_wlc++;
                if (qb.size() == 0 || {4'b0, b_wl} != qb[0].wl) b_bad = 1'b1;
            end
            if (b_bl_oe) begin
                b_oec++;
                if (qb.size() == 0 || b_bl_o != qb[0].wd || b_blb_o != ~qb[0].wd) b_bad = 1'b1;
            end
            if (b_if.rsp_valid) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_rsp", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    chk_rsp("b", eb, b_if.rsp_rdata, b_if.rsp_err, b_wlc, b_oec, b_nrdy, b_bad);
                    b_rdy_chk = 1'b1;
                end
                b_wlc = 0; b_oec = 0; b_nrdy = 0; b_bad = 1'b0;
            end
        end
    end

    // Issue one request; expectation pushed when acceptance is certain (ready seen before the edge)
    task automatic issue(bit to_b, logic we, logic [3:0] addr, logic [7:0] wd, bit push);
        int t;
        @(negedge clk);
        if (to_b) begin
            b_if.req_we = we; b_if.req_addr = addr; b_if.req_wdata = wd; b_if.req_valid = 1'b1;
        end else begin
            a_if.req_we = we; a_if.req_addr = addr; a_if.req_wdata = wd; a_if.req_valid = 1'b1;
        end
        t = 0;
        while (!(to_b ? b_if.req_ready : a_if.req_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", (t >= 50), 0);
        if (push) begin
            if (to_b) qb.push_back(mk(we, int'(addr), wd, 12, 4, 8'h96, 1'b0));
            else begin
                qa.push_back(mk(we, int'(addr), wd, 16, 2, exp_mem[addr], flt));
                if (we) exp_mem[addr] = wd;
            end
        end
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; the latched copy must be used
        if (to_b) begin
            b_if.req_valid = 1'b0; b_if.req_we = ~we; b_if.req_addr = ~addr; b_if.req_wdata = ~wd;
        end else begin
            a_if.req_valid = 1'b0; a_if.req_we = ~we; a_if.req_addr = ~addr; a_if.req_wdata = ~wd;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (t >= 100), 0);
        repeat (2) @(negedge clk);
    endtask

    logic [3:0] held_tbl [5] = '{4'd9, 4'd3, 4'd6, 4'd4, 4'd1};
    int saw;

    initial begin
        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0; b_if.req_wdata = '0;
        for (int r = 0; r < 16; r++) exp_mem[r] = init_val(r);
        repeat (3) @(posedge clk);
        load = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_wl", a_wl, 0);
        chk("rst_bl_oe", a_bl_oe, 0);
        chk("rst_bl_o", a_bl_o, 0);
        chk("rst_blb_o", a_blb_o, 0);
        chk("rst_rsp_valid", a_if.rsp_valid, 0);
        chk("rst_rsp_rdata", a_if.rsp_rdata, 0);
        chk("rst_rsp_err", a_if.rsp_err, 0);
        chk("rst_req_ready", a_if.req_ready, 1);

        // Write/read-back and no-disturb on a neighbouring row
        issue(0, 1'b1, 4'd3, 8'hA5, 1);
        issue(0, 1'b0, 4'd3, 8'h00, 1);
        issue(0, 1'b0, 4'd4, 8'h00, 1);
        wait_idle();

        // Floating pairs
        flt = 1'b1;
        issue(0, 1'b0, 4'd5, 8'h00, 1);
        wait_idle();
        flt = 1'b0;

        // Longer wordline, 12-row array, out-of-range read and write
        issue(1, 1'b0, 4'd2, 8'h00, 1);
        issue(1, 1'b0, 4'd13, 8'h00, 1);
        issue(1, 1'b1, 4'd13, 8'h77, 1);
        issue(1, 1'b1, 4'd11, 8'h42, 1);
        wait_idle();

        // Held req_valid with address changing every cycle
        a_if.req_we = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a_if.req_addr  = held_tbl[i % 5];
            a_if.req_valid = 1'b1;
            if (a_if.req_ready) qa.push_back(mk(1'b0, int'(held_tbl[i % 5]), 8'h00, 16, 2,
                                                exp_mem[held_tbl[i % 5]], 1'b0));
        end
        @(posedge clk);
        #1 a_if.req_valid = 1'b0;
        wait_idle();

        // Reset during the wordline pulse of a write
        issue(0, 1'b1, 4'd7, 8'hC3, 1);
        saw = 0;
        while (a_wl == 0 && saw < 20) begin
            @(negedge clk);
            saw++;
        end
        chk("abort_reach_wl_on", a_wl, 16'h0080);
        #2 rst_n = 1'b0;
        #1;
        qa.delete();
        chk("abort_wl_immediate", a_wl, 0);
        chk("abort_bl_oe_immediate", a_bl_oe, 0);
        chk("abort_bl_o_immediate", a_bl_o, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("abort_ready_first_edge", a_if.req_ready, 1);
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (a_if.rsp_valid) saw++;
        end
        chk("abort_no_rsp", saw, 0);

        // Array content survives controller reset
        issue(0, 1'b0, 4'd3, 8'h00, 1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mc_col_ctrl.md
Name: mc_col_ctrl

Overview:
- Synchronous access controller for a column array of mc bitcells. Each cell column has a complementary bitline pair and each row has one wordline.
- Converts single-word host read/write requests into the bitline and wordline sequence the cells need.
- Write: drives the bitline pairs strongly (overpowering the cells' weak drive) and pulses one wordline.
- Read: releases the bitlines, pulses the wordline, and samples the pairs while the cells drive them.

Parameters:
- ROWS, 16, number of wordlines (cell rows).
- ADDR_W, 4, row address width; ROWS <= 2**ADDR_W is required.
- WIDTH, 8, word width (number of bitline pairs).
- WL_CYC, 2, cycles the wordline stays asserted; >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target row.
- req_wdata  input  WIDTH  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  WIDTH  read data; valid with rsp_valid.
- rsp_err  output  1  error flag; valid with rsp_valid.
- wl  output  ROWS  wordlines, one-hot or zero.
- bl_oe  output  1  bitline drive enable; 0 = released (high-Z at the pad wrapper).
- bl_o  output  WIDTH  true-bitline drive value.
- blb_o  output  WIDTH  complement-bitline drive value.
- bl_i  input  WIDTH  sensed true bitlines.
- blb_i  input  WIDTH  sensed complement bitlines.

Behaviour:
- Reset (asynchronous, on rst_n low), effective immediately without waiting for a clock edge:
  - State goes to IDLE.
  - Outputs: wl=0, bl_oe=0, bl_o=0, blb_o=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 after release.
- Reset mid-operation aborts the operation: wordline and drivers are released at once, and no response is issued.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on a rising edge with req_valid&&req_ready.
  - On acceptance, req_we, req_addr and req_wdata are registered; later changes on those inputs are ignored.
  - One outstanding request at a time. Back-to-back requests are accepted no earlier than the cycle after rsp_valid.
- States: IDLE -> SETUP -> WL_ON -> HOLD -> DONE -> IDLE.
  - SETUP (1 cycle):
    - Write: bl_oe=1, bl_o=wdata, blb_o=~wdata.
    - Read: bl_oe=0.
    - wl=0 in both cases.
  - WL_ON (WL_CYC cycles): wl[addr]=1, all other wordlines 0. Bitline drive is as in SETUP.
    - Read: bl_i and blb_i are captured on the edge that ends the last WL_ON cycle, so sampling happens while the wordline is still high.
  - HOLD (1 cycle): wl=0. A write keeps driving the bitlines through HOLD for hold margin. bl_oe drops on HOLD exit.
  - DONE (1 cycle): rsp_valid=1, bl_oe=0, wl=0.
- Latency: rsp_valid is high exactly WL_CYC+3 cycles after the accepting edge (SETUP + WL_ON×WL_CYC + HOLD + DONE).
- rsp_rdata and rsp_err hold their values until the next DONE.
- Read result:
  - rsp_rdata = sampled bl_i.
  - rsp_err = OR over bits of (bl_i == blb_i), i.e. any pair not complementary (floating or contended).
- Write result: rsp_rdata=0, rsp_err=0.
- Out-of-range address (req_addr >= ROWS):
  - The full state sequence and timing still run, but wl stays 0 throughout.
  - A write never asserts bl_oe.
  - rsp_err=1, rsp_rdata=0.
- Wordline safety: at most one wl bit is high in any cycle, and wl is never high in SETUP, HOLD, DONE or IDLE.
- bl_o and blb_o are always complementary while bl_oe=1.
- All outputs are registered, with no combinational path from bl_i/blb_i to any output.
- req_valid high during a busy period is ignored; no queueing.

Test Plan:
- Write then read, with ROWS=16, WIDTH=8, WL_CYC=2 and a behavioural mc array attached:
  - Write 0xA5 to row 3 -> bl_oe=1 with bl_o=0xA5 and blb_o=0x5A; wl=0x0008 for exactly 2 cycles.
  - Then read row 3 -> rsp_rdata=0xA5, rsp_err=0.
  - Then read row 4 (pre-written 0x3C) -> 0x3C, showing no disturb.
- Latency check: accept at edge N -> rsp_valid high only in cycle N+5, req_ready low for cycles N+1..N+5 and high at N+6. With WL_CYC=4 -> rsp_valid at N+7.
- Floating bitlines: read with bl_i=blb_i=0xFF forced -> rsp_err=1, rsp_rdata=0xFF.
- Out-of-range address: set ROWS=12 and read or write address 13 -> wl=0 and bl_oe=0 throughout, rsp_valid at N+5 with rsp_err=1 and rsp_rdata=0.
- Reset mid-write: assert rst_n=0 during WL_ON -> wl=0 and bl_oe=0 immediately, with no clock edge needed. No rsp_valid follows, and req_ready=1 on the first edge after release.
- Held req_valid with changing req_addr during busy -> exactly one access per DONE, each using the address latched at acceptance.
